// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix operand sequencer.
// Word/matrix sizes, FSM encoding and a few FP32 literals.
package matrix_pkg;

  localparam int WORD_W = 32;
  localparam int DIM    = 4;
  localparam int N_ELEM = DIM * DIM;

  typedef logic [WORD_W-1:0] word_t;
  typedef word_t [N_ELEM-1:0] mat_t;
  typedef word_t [DIM-1:0]    vec_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE,
    DONE
  } state_t;

  localparam word_t FP_ONE     = 32'h3F800000;
  localparam word_t FP_TWO     = 32'h40000000;
  localparam word_t FP_SIXTEEN = 32'h41800000;

  // Row-major flat index of element (r, c).
  function automatic logic [3:0] mat_idx(
    input logic [1:0] r,
    input logic [1:0] c
  );
    return {r, c};
  endfunction

endpackage

// File: rtl/mat_store.sv
// 16x32 register array: async clear, one write port, all words
// exposed as combinational read taps (q).
module mat_store
  import matrix_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [3:0] waddr,
  input  word_t      wdata,
  output mat_t       q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (we) begin
      q[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/matrix_seq.sv
// Operand sequencer / result buffer for a 4-wide FP32 dot stage.
// Loads A/B word-wise, walks the 16 C elements, reads C back.
module matrix_seq
  import matrix_pkg::*;
#(
  parameter int DP_LATENCY = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic              load_sel,
  input  logic [3:0]        load_addr,
  input  logic [WORD_W-1:0] load_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] arr1_0,
  output logic [WORD_W-1:0] arr1_1,
  output logic [WORD_W-1:0] arr1_2,
  output logic [WORD_W-1:0] arr1_3,
  output logic [WORD_W-1:0] arr2_0,
  output logic [WORD_W-1:0] arr2_1,
  output logic [WORD_W-1:0] arr2_2,
  output logic [WORD_W-1:0] arr2_3,
  input  logic [WORD_W-1:0] dp_result,
  input  logic [3:0]        rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  localparam logic [7:0] WAIT_INIT = 8'(DP_LATENCY - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] k;
  logic [7:0] wcnt;
  vec_t       arr1_q;
  vec_t       arr2_q;

  logic       ld_ok;
  logic       issue;
  logic       cap;
  logic       a_we;
  logic       b_we;

  mat_t       a_q;
  mat_t       b_q;
  mat_t       c_q;

  assign a_we = load_valid & ld_ok & ~load_sel;
  assign b_we = load_valid & ld_ok &  load_sel;

  mat_store u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (a_we),
    .waddr (load_addr),
    .wdata (load_data),
    .q     (a_q)
  );

  mat_store u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (b_we),
    .waddr (load_addr),
    .wdata (load_data),
    .q     (b_q)
  );

  mat_store u_c (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cap),
    .waddr (k),
    .wdata (dp_result),
    .q     (c_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    ld_ok     = 1'b0;
    issue     = 1'b0;
    cap       = 1'b0;
    unique case (state)
      IDLE: begin
        ld_ok = 1'b1;
        if (start) state_nxt = ISSUE;
      end
      ISSUE: begin
        busy      = 1'b1;
        issue     = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (wcnt == 8'd0) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        busy      = 1'b1;
        cap       = 1'b1;
        state_nxt = (k == 4'd15) ? DONE : ISSUE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are registered on the edge leaving ISSUE, so a word
  // written in the start cycle is already in the store here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k       <= '0;
      wcnt    <= '0;
      arr1_q  <= '0;
      arr2_q  <= '0;
      rd_data <= '0;
    end else begin
      rd_data <= c_q[rd_addr];
      if (issue) begin
        wcnt <= WAIT_INIT;
        for (int n = 0; n < DIM; n++) begin
          arr1_q[n] <= a_q[mat_idx(k[3:2], 2'(n))];
          arr2_q[n] <= b_q[mat_idx(2'(n), k[1:0])];
        end
      end else if (state == WAIT && wcnt != 8'd0) begin
        wcnt <= wcnt - 8'd1;
      end
      if (cap && k != 4'd15) begin
        k <= k + 4'd1;
      end
      if (state == DONE || (state == IDLE && start)) begin
        k <= '0;
      end
    end
  end

  assign arr1_0 = arr1_q[0];
  assign arr1_1 = arr1_q[1];
  assign arr1_2 = arr1_q[2];
  assign arr1_3 = arr1_q[3];
  assign arr2_0 = arr2_q[0];
  assign arr2_1 = arr2_q[1];
  assign arr2_2 = arr2_q[2];
  assign arr2_3 = arr2_q[3];

endmodule

// File: tb/tb_matrix_seq.sv
// Scoreboard bench for matrix_seq with a behavioural
// dot-product stage returning results 8 cycles after operands.
module tb_matrix_seq;
  import matrix_pkg::*;

  localparam int LAT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_sel = 1'b0;
  logic [3:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] arr1_0, arr1_1, arr1_2, arr1_3;
  logic [31:0] arr2_0, arr2_1, arr2_2, arr2_3;
  logic [31:0] dp_result;
  logic [3:0]  rd_addr = '0;
  logic [31:0] rd_data;

  always #5 clk = ~clk;

  matrix_seq #(.DP_LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_sel   (load_sel),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .arr1_0     (arr1_0),
    .arr1_1     (arr1_1),
    .arr1_2     (arr1_2),
    .arr1_3     (arr1_3),
    .arr2_0     (arr2_0),
    .arr2_1     (arr2_1),
    .arr2_2     (arr2_2),
    .arr2_3     (arr2_3),
    .dp_result  (dp_result),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int done_seen = 0;

  function automatic void chk(
    input string        nm,
    input logic [255:0] act,
    input logic [255:0] exp
  );
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endfunction

  // FP32 <-> real for normal numbers and zero.
  function automatic real f2r(input logic [31:0] b);
    logic [63:0] d;
    logic [10:0] e;
    if (b[30:0] == 31'd0) return 0.0;
    e = 11'(b[30:23]) + 11'd896;
    d = {b[31], e, b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] dot4(
    input logic [31:0] a0, a1, a2, a3,
    input logic [31:0] b0, b1, b2, b3
  );
    real s;
    s = f2r(a0) * f2r(b0) + f2r(a1) * f2r(b1)
      + f2r(a2) * f2r(b2) + f2r(a3) * f2r(b3);
    return r2f(s);
  endfunction

  logic [31:0] pipe [LAT] = '{default: 32'd0};

  always @(posedge clk) begin
    pipe[0] <= dot4(arr1_0, arr1_1, arr1_2, arr1_3,
                    arr2_0, arr2_1, arr2_2, arr2_3);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign dp_result = pipe[LAT-1];

  always @(negedge clk) if (done) done_seen++;

  // Read-port scoreboard.
  logic [31:0] exp_q [$];
  logic [3:0]  adr_q [$];
  logic        rd_req = 1'b0;
  logic        rd_req_q = 1'b0;

  always @(posedge clk) rd_req_q <= rd_req;

  always @(negedge clk) begin
    logic [31:0] e;
    logic [3:0]  a;
    if (rd_req_q) begin
      if (exp_q.size() == 0) begin
        chk("rd scoreboard empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        a = adr_q.pop_front();
        chk($sformatf("rd C[%0d]", a), rd_data, e);
      end
    end
  end

  word_t seq_tab [16] = '{
    32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
    32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
    32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
    32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000
  };
  word_t id_tab  [16];
  word_t two_tab [16];
  word_t sxt_tab [16];
  word_t zero_tab[16];
  word_t sim_tab [16];

  logic [255:0] exp_arr;
  bit           chk_arr = 0;

  task automatic load_mat(input logic sel, input word_t m[16]);
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_sel   = sel;
      load_addr  = 4'(a);
      load_data  = m[a];
    end
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic read_all(input word_t m[16]);
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      rd_addr = 4'(a);
      rd_req  = 1'b1;
      exp_q.push_back(m[a]);
      adr_q.push_back(4'(a));
    end
    @(negedge clk);
    rd_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // mode 0 plain, 1 mid-run start/load, 2 reset in element 5,
  // 3 load B[15]=4.0 together with start.
  task automatic run(input int mode);
    int base;
    int got;
    base = done_seen;
    got  = 0;
    @(negedge clk);
    start = 1'b1;
    if (mode == 3) begin
      load_valid = 1'b1;
      load_sel   = 1'b1;
      load_addr  = 4'd15;
      load_data  = 32'h40800000;
    end
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start      = 1'b0;
        load_valid = 1'b0;
      end
      if (chk_arr && n >= 62 && n <= 71) begin
        chk($sformatf("arr k6 cyc %0d", n),
            {arr1_3, arr1_2, arr1_1, arr1_0,
             arr2_3, arr2_2, arr2_1, arr2_0},
            exp_arr);
      end
      if (mode == 1 && n == 30) begin
        start      = 1'b1;
        load_valid = 1'b1;
        load_sel   = 1'b0;
        load_addr  = 4'd0;
        load_data  = 32'hDEADBEEF;
      end
      if (mode == 1 && n == 31) begin
        start      = 1'b0;
        load_valid = 1'b0;
      end
      if (mode == 2 && n == 55) begin
        rst_n = 1'b0;
        #1;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("abort no done", done_seen - base, 0);
        return;
      end
      if (done && got == 0) got = n;
      if (got != 0 && n >= got + 20) break;
    end
    chk("done cycle", got, 16 * (LAT + 2) + 1);
    chk("done pulses", done_seen - base, 1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      id_tab[i]   = (i % 5 == 0) ? FP_ONE : 32'd0;
      two_tab[i]  = FP_TWO;
      sxt_tab[i]  = FP_SIXTEEN;
      zero_tab[i] = 32'd0;
      sim_tab[i]  = seq_tab[i];
    end
    sim_tab[15] = 32'h40800000;

    #12;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst arr",
        {arr1_3, arr1_2, arr1_1, arr1_0,
         arr2_3, arr2_2, arr2_1, arr2_0}, 0);
    chk("rst rd_data", rd_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    read_all(zero_tab);

    // Identity times 1..16.
    load_mat(1'b0, id_tab);
    load_mat(1'b1, seq_tab);
    exp_arr = {32'h0, 32'h0, 32'h3F800000, 32'h0,
               32'h41700000, 32'h41300000,
               32'h40E00000, 32'h40400000};
    chk_arr = 1;
    run(0);
    chk_arr = 0;
    read_all(seq_tab);

    // All 2.0.
    load_mat(1'b0, two_tab);
    load_mat(1'b1, two_tab);
    exp_arr = {8{32'h40000000}};
    chk_arr = 1;
    run(0);
    chk_arr = 0;
    read_all(sxt_tab);

    // Start and load ignored while busy.
    load_mat(1'b0, id_tab);
    load_mat(1'b1, seq_tab);
    run(1);
    read_all(seq_tab);

    // Write and start in the same IDLE cycle.
    run(3);
    read_all(sim_tab);

    // Reset during element 5, then a clean rerun.
    run(2);
    read_all(zero_tab);
    load_mat(1'b0, id_tab);
    load_mat(1'b1, seq_tab);
    run(0);
    read_all(seq_tab);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_seq.md
Name: matrix_seq

Overview:
- Operand sequencer and result buffer directly upstream of the 4-element FP32 dot-product stage (matrix_mult).
- Holds two 4x4 single-precision matrices A and B, loaded one word at a time.
- On start, presents row i of A and column j of B to the dot-product stage for each of the 16 output elements, waits a fixed latency, and captures each result into matrix C.
- C is readable through a registered read port; the block performs no FP arithmetic itself.

Parameters:
- DP_LATENCY, 8, clock cycles from stable operands to valid dp_result; legal range 1..255.
- WORD_W, 32, FP32 word width; fixed at 32, never overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_valid  in  1  write one matrix word this cycle.
- load_sel  in  1  0 = write A, 1 = write B.
- load_addr  in  4  row-major index, row*4+col.
- load_data  in  32  FP32 word.
- start  in  1  single-cycle request to compute C = A x B.
- busy  out  1  computation in progress.
- done  out  1  one-cycle pulse when C is complete.
- arr1_0..arr1_3  out  32 each  A[i][0..3], to the dot-product stage.
- arr2_0..arr2_3  out  32 each  B[0..3][j], to the dot-product stage.
- dp_result  in  32  dot-product stage output (its ans).
- rd_addr  in  4  C index, row*4+col.
- rd_data  out  32  C[rd_addr], registered.

Behaviour:
- Reset (async assert, sync release):
  - All A, B and C words clear to 0.
  - State goes to IDLE and element counter k = 0.
  - busy, done, rd_data and all arr outputs are 0.
- Storage: 16 words each for A, B and C, row-major.
- Load:
  - Accepted only in IDLE; the write completes at the clock edge.
  - load_valid outside IDLE is ignored silently and no storage changes.
- Start:
  - Accepted only in IDLE; start in any other state is ignored.
  - If load_valid and start are both high in the same IDLE cycle, the write lands first and the run uses the new word.
- Operand mapping for element k, with i = k[3:2] and j = k[1:0]:
  - arr1_n = A[4i+n].
  - arr2_n = B[4n+j].
  - The arr registers load in ISSUE and hold stable through WAIT and CAPTURE.
- FSM:
  - IDLE: busy=0. On accepted start -> ISSUE with k=0.
  - ISSUE (1 cycle): register operands for k; load wait counter with DP_LATENCY-1; -> WAIT.
  - WAIT (DP_LATENCY cycles): count down to 0, then -> CAPTURE.
  - CAPTURE (1 cycle): C[k] <= dp_result. If k==15 -> DONE; else k++ and -> ISSUE.
  - DONE (1 cycle): done=1, busy=0; -> IDLE with k=0.
- busy is 1 exactly in ISSUE, WAIT and CAPTURE.
- Timing:
  - Each element takes DP_LATENCY+2 cycles.
  - If start is sampled at edge T, done is high in cycle T + 16*(DP_LATENCY+2) + 1.
- arr outputs keep their last values in IDLE and DONE.
- Read port:
  - rd_data <= C[rd_addr] every cycle, giving 1-cycle latency, in every state.
  - A C word written in CAPTURE is visible on rd_data two edges after that CAPTURE edge when addressed.
- Reset mid-run: aborts immediately and clears all storage. No done pulse is produced. The next start runs normally.
- Back-to-back runs: start in the cycle after DONE (IDLE) is accepted.
- No wrap issues: k is 4 bits and saturates by the FSM at 15; load_addr and rd_addr use the full 4-bit range.

Decomposition:
- Shared package matrix_pkg holds:
  - FP32 word width constant.
  - Matrix dimension constant (4).
  - FSM state encoding: IDLE, ISSUE, WAIT, CAPTURE, DONE.
  - FP32 constants for the bench: 1.0 = 32'h3F800000, 2.0 = 32'h40000000, 16.0 = 32'h41800000.
- One sub-module: mat_store, a 16x32 register array with async clear, one write port and combinational read taps. It is instantiated three times (A, B, C).
- Sequencing FSM and operand muxing stay in matrix_seq.

Test Plan:
- Reset: hold rst_n=0 mid-clock.
  - busy=0, done=0, arr*=0.
  - rd_data=0 for every rd_addr after release.
- Identity product, DP_LATENCY=8, with a bench model returning the dot product 8 cycles after operands settle:
  - Load A=I (1.0 on the diagonal, 0 elsewhere) and B[k]=float(k+1).
  - Pulse start; done is high exactly 161 cycles after the start edge.
  - C[k]=B[k] for all k, e.g. C[6]=32'h40E00000 (7.0).
- Uniform product: all A and B words = 2.0.
  - Every C word = 32'h41800000 (16.0).
  - During element k=6: arr1_n = A[4+n] and arr2_n = B[4n+2], stable for all 10 cycles.
- Protocol guards: during a run, pulse start and apply load_valid to A[0] with 32'hDEADBEEF.
  - Only one done pulse occurs.
  - A[0] is unchanged and the results match the original operands.
- Simultaneous load and start in IDLE: write B[15]=4.0 and assert start in the same cycle.
  - C[15] reflects B[15]=4.0.
- Reset mid-run: assert rst_n=0 during element 5.
  - busy falls asynchronously; no done pulse.
  - rd_data=0 for all C.
  - Reload operands and restart: the run completes correctly.
